// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 memory controller: FSM states, R_W direction
// and the keyboard/display device register addresses.
package lc3_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard/display device registers: address decode, read mux and the
// kb_ack / dsp_strobe side-effect pulses. Used only when LC3_MMIO_EN is defined.
module lc3_mmio_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        access,
  input  logic        r_w,
  output logic        hit,
  output logic [15:0] rdata,
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic        kb_ack,
  output logic [7:0]  dsp_data,
  output logic        dsp_strobe,
  input  logic        dsp_ready
);
  assign hit = (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);

  always_comb begin
    rdata = 16'h0000;
    case (addr)
      KBSR_ADDR: rdata = {kb_valid, 15'b0};
      KBDR_ADDR: rdata = {8'b0, kb_data};
      DSR_ADDR:  rdata = {dsp_ready, 15'b0};
      default:   rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kb_ack     <= 1'b0;
      dsp_strobe <= 1'b0;
      dsp_data   <= 8'h00;
    end else begin
      kb_ack     <= access && (r_w == RW_READ)  && (addr == KBDR_ADDR);
      dsp_strobe <= access && (r_w == RW_WRITE) && (addr == DDR_ADDR);
      if (access && (r_w == RW_WRITE) && (addr == DDR_ADDR))
        dsp_data <= wdata[7:0];
    end
  end
endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR holder and req/ack memory transaction engine returning R (ready).
// Define LC3_MMIO_EN to add the keyboard/display device registers at xFE00-xFE06.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  output logic [15:0] mar_out,
  output logic [15:0] mdr_out,
  output logic        ready,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
`ifdef LC3_MMIO_EN
  input  logic [7:0]  kb_data,
  input  logic        kb_valid,
  output logic        kb_ack,
  output logic [7:0]  dsp_data,
  output logic        dsp_strobe,
  input  logic        dsp_ready,
`endif
  input  logic        mem_ack
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state, state_nx;
  logic [15:0]     mar, mdr;
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  logic            to_hit;
  logic            mmio_hit;
  logic [15:0]     mmio_rdata;

`ifdef LC3_MMIO_EN
  lc3_mmio_regs u_mmio (
    .clk        (clk),
    .rst        (rst),
    .addr       (mar),
    .wdata      (mdr),
    .access     ((state == IDLE) && mio_en),
    .r_w        (r_w),
    .hit        (mmio_hit),
    .rdata      (mmio_rdata),
    .kb_data    (kb_data),
    .kb_valid   (kb_valid),
    .kb_ack     (kb_ack),
    .dsp_data   (dsp_data),
    .dsp_strobe (dsp_strobe),
    .dsp_ready  (dsp_ready)
  );
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = 16'h0000;
`endif

  // Abort fires on the edge that would make the TIMEOUT-th waiting cycle end.
  assign to_hit  = (TIMEOUT != 0) && (to_cnt == TO_LAST);
  assign mar_out = mar;
  assign mdr_out = mdr;
  assign ready   = (state == DONE);
  assign bus_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mio_en) state_nx = mmio_hit ? DONE : REQ;
      REQ:     if (mem_ack || to_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mar       <= 16'h0000;
      mdr       <= 16'h0000;
      to_cnt    <= '0;
      err_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_mar) mar <= bus_in;
          if (ld_mdr && !mio_en) mdr <= bus_in;
          // Transaction latches the pre-load MAR even if ld_mar is also high.
          if (mio_en) begin
            if (mmio_hit) begin
              if (r_w == RW_READ) mdr <= mmio_rdata;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= r_w;
              mem_addr  <= mar;
              mem_wdata <= mdr;
              to_cnt    <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we == RW_READ) mdr <= mem_rdata;
          end else if (to_hit) begin
            mem_req <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed scenarios plus randomized
// transactions against a simple MAR/MDR reference model.
module tb_lc3_mem_ctrl;
  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mar_out, mdr_out;
  logic        ready, bus_err, mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef LC3_MMIO_EN
  logic [7:0]  kb_data, dsp_data;
  logic        kb_valid, kb_ack, dsp_strobe, dsp_ready;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic [15:0] m_mar, m_mdr;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.TIMEOUT(TB_TIMEOUT), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .mar_out(mar_out), .mdr_out(mdr_out),
    .ready(ready), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef LC3_MMIO_EN
    .kb_data(kb_data), .kb_valid(kb_valid), .kb_ack(kb_ack),
    .dsp_data(dsp_data), .dsp_strobe(dsp_strobe), .dsp_ready(dsp_ready),
`endif
    .mem_ack(mem_ack)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    bus_in = a; ld_mar = 1'b1; cyc(); ld_mar = 1'b0;
    bus_in = d; ld_mdr = 1'b1; cyc(); ld_mdr = 1'b0;
    m_mar = a; m_mdr = d;
  endtask

  // Drives one memory transaction and records what was observed on the bus.
  task automatic run_txn(input logic rw, input int ack_at, input logic [15:0] rd,
                         input logic busy, output int req_cyc, output logic rdy_drop,
                         output logic err_drop, output int rdy_tot, output logic [15:0] a,
                         output logic we, output logic [15:0] wd, output logic stable);
    mio_en = 1'b1; r_w = rw; cyc(); mio_en = 1'b0;
    a = mem_addr; we = mem_we; wd = mem_wdata; stable = 1'b1;
    req_cyc = mem_req ? 1 : 0; rdy_tot = 0; rdy_drop = 1'b0; err_drop = 1'b0;
    for (int i = 1; i <= 50 && mem_req; i++) begin
      if (busy) begin
        ld_mar = i[0]; ld_mdr = ~i[0]; bus_in = i[0] ? 16'h5555 : 16'hAAAA;
      end
      if (ack_at == i) begin mem_ack = 1'b1; mem_rdata = rd; end
      cyc(); mem_ack = 1'b0;
      rdy_tot += int'(ready);
      if (mem_req) begin
        req_cyc++;
        if (mem_addr !== a || mem_we !== we || mem_wdata !== wd) stable = 1'b0;
      end else begin
        rdy_drop = ready; err_drop = bus_err;
      end
    end
    cyc(); rdy_tot += int'(ready);
    ld_mar = 1'b0; ld_mdr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    n_chk++; if (mar_out !== 16'h0 || mdr_out !== 16'h0) begin n_fail++;
      $display("FAIL reset_regs got mar=%h mdr=%h exp 0/0", mar_out, mdr_out); end
    n_chk++; if ({ready, bus_err, mem_req, mem_we} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctl got rdy/err/req/we=%b exp 0000", {ready, bus_err, mem_req, mem_we}); end
    n_chk++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_fail++;
      $display("FAIL reset_bus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata); end
    m_mar = 16'h0; m_mdr = 16'h0;
  endtask

  task automatic test_read();
    int rc, rt; logic rd0, er0, we, st; logic [15:0] a, wd;
    load(16'h3000, 16'h0101);
    run_txn(1'b0, 2, 16'h1234, 1'b0, rc, rd0, er0, rt, a, we, wd, st);
    n_chk++; if (a !== 16'h3000 || we !== 1'b0) begin n_fail++;
      $display("FAIL read_bus got addr=%h we=%b exp 3000/0", a, we); end
    n_chk++; if (rc !== 2 || !st) begin n_fail++;
      $display("FAIL read_req got cycles=%0d stable=%b exp 2/1", rc, st); end
    n_chk++; if (mdr_out !== 16'h1234) begin n_fail++;
      $display("FAIL read_mdr got %h exp 1234", mdr_out); end
    n_chk++; if (rd0 !== 1'b1 || rt !== 1 || er0 !== 1'b0) begin n_fail++;
      $display("FAIL read_ready got at_drop=%b total=%0d err=%b exp 1/1/0", rd0, rt, er0); end
  endtask

  task automatic test_write();
    int rc, rt; logic rd0, er0, we, st; logic [15:0] a, wd;
    load(16'h4000, 16'hBEEF);
    run_txn(1'b1, 1, 16'h7777, 1'b0, rc, rd0, er0, rt, a, we, wd, st);
    n_chk++; if (a !== 16'h4000 || we !== 1'b1 || wd !== 16'hBEEF) begin n_fail++;
      $display("FAIL write_bus got addr=%h we=%b wd=%h exp 4000/1/beef", a, we, wd); end
    n_chk++; if (rc !== 1 || mdr_out !== 16'hBEEF) begin n_fail++;
      $display("FAIL write_mdr got cycles=%0d mdr=%h exp 1/beef", rc, mdr_out); end
    n_chk++; if (rd0 !== 1'b1 || rt !== 1) begin n_fail++;
      $display("FAIL write_ready got at_drop=%b total=%0d exp 1/1", rd0, rt); end
  endtask

  task automatic test_busy();
    int rc, rt; logic rd0, er0, we, st; logic [15:0] a, wd;
    load(16'h1357, 16'h2468);
    run_txn(1'b1, 3, 16'h0, 1'b1, rc, rd0, er0, rt, a, we, wd, st);
    n_chk++; if (!st || rc !== 3) begin n_fail++;
      $display("FAIL busy_hold got stable=%b cycles=%0d exp 1/3", st, rc); end
    n_chk++; if (mar_out !== 16'h1357 || mdr_out !== 16'h2468) begin n_fail++;
      $display("FAIL busy_regs got mar=%h mdr=%h exp 1357/2468", mar_out, mdr_out); end
  endtask

  task automatic test_timeout();
    int rc, rt; logic rd0, er0, we, st; logic [15:0] a, wd;
    load(16'h6000, 16'hCAFE);
    run_txn(1'b0, 0, 16'h0, 1'b0, rc, rd0, er0, rt, a, we, wd, st);
    n_chk++; if (rc !== TB_TIMEOUT) begin n_fail++;
      $display("FAIL timeout_len got %0d exp %0d", rc, TB_TIMEOUT); end
    n_chk++; if (rd0 !== 1'b1 || er0 !== 1'b1 || rt !== 1) begin n_fail++;
      $display("FAIL timeout_pulse got rdy=%b err=%b total=%0d exp 1/1/1", rd0, er0, rt); end
    n_chk++; if (mdr_out !== 16'hCAFE || bus_err !== 1'b0) begin n_fail++;
      $display("FAIL timeout_after got mdr=%h err=%b exp cafe/0", mdr_out, bus_err); end
  endtask

  task automatic test_reset_mid();
    int rdy = 0;
    load(16'h7777, 16'h1111);
    mio_en = 1'b1; r_w = 1'b0; cyc(); mio_en = 1'b0; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    n_chk++; if (mem_req !== 1'b0 || mar_out !== 16'h0 || mdr_out !== 16'h0) begin n_fail++;
      $display("FAIL rstmid_state got req=%b mar=%h mdr=%h exp 0/0/0", mem_req, mar_out, mdr_out); end
    mem_ack = 1'b1; mem_rdata = 16'hFFFF; cyc(); mem_ack = 1'b0;
    rdy += int'(ready) + int'(bus_err);
    cyc(); rdy += int'(ready) + int'(bus_err);
    n_chk++; if (rdy !== 0 || mdr_out !== 16'h0 || mem_req !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_late got pulses=%0d mdr=%h req=%b exp 0/0/0", rdy, mdr_out, mem_req); end
    m_mar = 16'h0; m_mdr = 16'h0;
  endtask

  task automatic test_ack_idle();
    load(16'h0ABC, 16'h0DEF);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD; cyc(); mem_ack = 1'b0; cyc();
    n_chk++; if (mdr_out !== 16'h0DEF || ready !== 1'b0 || mem_req !== 1'b0) begin n_fail++;
      $display("FAIL ack_idle got mdr=%h rdy=%b req=%b exp 0def/0/0", mdr_out, ready, mem_req); end
  endtask

  // Consecutive transactions with no idle gap beyond the mandatory one; the
  // model carries MAR/MDR across them.
  task automatic test_random();
    int rc, rt, ack; logic rd0, er0, we, st, rw; logic [15:0] a, wd, rdv, exp_mdr;
    int bad = 0;
    for (int n = 0; n < 24; n++) begin
      if (n % 3 == 0) load(16'($urandom), 16'($urandom));
      rw = 1'($urandom); ack = int'($urandom_range(1, 3)); rdv = 16'($urandom);
      exp_mdr = (rw == 1'b1) ? m_mdr : rdv;
      run_txn(rw, ack, rdv, 1'b0, rc, rd0, er0, rt, a, we, wd, st);
      if (a !== m_mar || we !== rw || wd !== m_mdr || rc !== ack || !st ||
          rd0 !== 1'b1 || rt !== 1 || er0 !== 1'b0 || mdr_out !== exp_mdr) begin
        bad++;
        $display("FAIL rand_txn%0d got a=%h we=%b wd=%h cyc=%0d rdy=%b/%0d mdr=%h exp a=%h we=%b wd=%h cyc=%0d rdy=1/1 mdr=%h",
                 n, a, we, wd, rc, rd0, rt, mdr_out, m_mar, rw, m_mdr, ack, exp_mdr);
      end
      m_mdr = exp_mdr;
    end
    n_chk++; if (bad !== 0) begin n_fail++;
      $display("FAIL rand_summary got %0d bad txns exp 0", bad); end
  endtask

`ifdef LC3_MMIO_EN
  task automatic test_mmio();
    int req_seen = 0;
    kb_data = 8'h41; kb_valid = 1'b1; dsp_ready = 1'b1;
    load(16'hFE02, 16'h0000);
    mio_en = 1'b1; r_w = 1'b0; cyc(); mio_en = 1'b0;
    n_chk++; if (mdr_out !== 16'h0041 || kb_ack !== 1'b1 || ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++;
      $display("FAIL mmio_kbdr got mdr=%h ack=%b rdy=%b req=%b exp 0041/1/1/0", mdr_out, kb_ack, ready, mem_req); end
    cyc();
    n_chk++; if (kb_ack !== 1'b0 || ready !== 1'b0) begin n_fail++;
      $display("FAIL mmio_kback got ack=%b rdy=%b exp 0/0", kb_ack, ready); end
    load(16'hFE00, 16'h0000);
    mio_en = 1'b1; r_w = 1'b0; cyc(); mio_en = 1'b0; cyc();
    n_chk++; if (mdr_out !== 16'h8000) begin n_fail++;
      $display("FAIL mmio_kbsr got %h exp 8000", mdr_out); end
    load(16'hFE06, 16'h0042);
    mio_en = 1'b1; r_w = 1'b1; cyc(); mio_en = 1'b0;
    req_seen += int'(mem_req);
    n_chk++; if (dsp_data !== 8'h42 || dsp_strobe !== 1'b1 || ready !== 1'b1 || req_seen !== 0) begin n_fail++;
      $display("FAIL mmio_ddr got data=%h stb=%b rdy=%b req=%0d exp 42/1/1/0", dsp_data, dsp_strobe, ready, req_seen); end
    cyc();
    n_chk++; if (dsp_strobe !== 1'b0 || mdr_out !== 16'h0042) begin n_fail++;
      $display("FAIL mmio_stb got stb=%b mdr=%h exp 0/0042", dsp_strobe, mdr_out); end
  endtask
`endif

  initial begin
    rst = 1'b1; bus_in = 16'h0; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0;
    r_w = 1'b0; mem_rdata = 16'h0; mem_ack = 1'b0;
`ifdef LC3_MMIO_EN
    kb_data = 8'h0; kb_valid = 1'b0; dsp_ready = 1'b0;
`endif
    test_reset();
    test_read();
    test_write();
    test_busy();
    test_timeout();
    test_reset_mid();
    test_ack_idle();
    test_random();
`ifdef LC3_MMIO_EN
    test_mmio();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
